// File: rtl/csr_master_apb_mt.sv
// APB target to N independent CSR master channels. Decodes the target from paddr[31:16],
// muxes the selected channel's response back and forces an error completion on timeout.
module csr_master_apb_mt #(
  parameter int unsigned N_TARGETS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = 32'hDEADDEAD
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              apb_request__paddr,
  input  logic                     apb_request__psel,
  input  logic                     apb_request__penable,
  input  logic                     apb_request__pwrite,
  input  logic [31:0]              apb_request__pwdata,
  output logic [31:0]              apb_response__prdata,
  output logic                     apb_response__pready,
  output logic                     apb_response__perr,
  output logic [N_TARGETS-1:0]     csr_request__valid,
  output logic                     csr_request__read_not_write,
  output logic [15:0]              csr_request__select,
  output logic [15:0]              csr_request__address,
  output logic [31:0]              csr_request__data,
  input  logic [N_TARGETS-1:0]     csr_response__acknowledge,
  input  logic [N_TARGETS-1:0]     csr_response__read_data_valid,
  input  logic [N_TARGETS-1:0]     csr_response__read_data_error,
  input  logic [32*N_TARGETS-1:0]  csr_response__read_data
);

  localparam int unsigned TIDX_W = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;
  localparam int unsigned TMR_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Expiry is detected one count early so pready lands exactly TIMEOUT_CYCLES after valid rises.
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT_CYCLES > 0) ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RDWAIT, S_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [TIDX_W-1:0]    r_tidx, w_acc_tidx;
  logic [N_TARGETS-1:0] r_valid, w_valid_nxt, w_acc_onehot, w_cur_onehot;
  logic                 r_rnw;
  logic [15:0]          r_select, r_address;
  logic [31:0]          r_data;
  logic [31:0]          r_prdata, w_prdata_nxt, w_rdata;
  logic                 r_pready, w_pready_nxt;
  logic                 r_perr, w_perr_nxt;
  logic [TMR_W-1:0]     r_timer, w_timer_nxt, w_timer_inc;
  logic                 w_accept, w_ack, w_rdv, w_rderr, w_timeout;
  logic                 w_unused;

  assign w_unused   = ^apb_request__paddr[1:0];
  assign w_acc_tidx = (N_TARGETS > 1) ? apb_request__paddr[16 +: TIDX_W] : '0;

  always_comb begin
    w_acc_onehot = '0;
    w_cur_onehot = '0;
    w_rdata      = '0;
    for (int unsigned k = 0; k < N_TARGETS; k++) begin
      if (k == 32'(w_acc_tidx)) w_acc_onehot[k] = 1'b1;
      if (k == 32'(r_tidx)) begin
        w_cur_onehot[k] = 1'b1;
        w_rdata         = csr_response__read_data[32*k +: 32];
      end
    end
  end

  assign w_ack       = |(csr_response__acknowledge & w_cur_onehot);
  assign w_rdv       = |(csr_response__read_data_valid & w_cur_onehot);
  assign w_rderr     = |(csr_response__read_data_error & w_cur_onehot);
  assign w_timer_inc = (r_timer == '1) ? r_timer : r_timer + 1'b1;
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_timer == TMR_LAST);

  always_comb begin
    w_state_nxt  = r_state;
    w_valid_nxt  = '0;
    w_prdata_nxt = '0;
    w_pready_nxt = 1'b0;
    w_perr_nxt   = 1'b0;
    w_timer_nxt  = r_timer;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (apb_request__psel && apb_request__penable) begin
          w_accept    = 1'b1;
          w_timer_nxt = '0;
          w_valid_nxt = w_acc_onehot;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        w_timer_nxt = w_timer_inc;
        if (w_ack) begin
          if (r_rnw) begin
            w_state_nxt = S_RDWAIT;
          end else begin
            w_state_nxt  = S_DONE;
            w_pready_nxt = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt  = S_DONE;
          w_pready_nxt = 1'b1;
          w_perr_nxt   = 1'b1;
          w_prdata_nxt = r_rnw ? ERR_DATA : '0;
        end else begin
          w_valid_nxt = r_valid;
        end
      end
      S_RDWAIT: begin
        w_timer_nxt = w_timer_inc;
        if (w_rdv) begin
          w_state_nxt  = S_DONE;
          w_pready_nxt = 1'b1;
          w_perr_nxt   = w_rderr;
          w_prdata_nxt = w_rderr ? ERR_DATA : w_rdata;
        end else if (w_timeout) begin
          w_state_nxt  = S_DONE;
          w_pready_nxt = 1'b1;
          w_perr_nxt   = 1'b1;
          w_prdata_nxt = ERR_DATA;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tidx    <= '0;
      r_valid   <= '0;
      r_rnw     <= 1'b0;
      r_select  <= '0;
      r_address <= '0;
      r_data    <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_perr    <= 1'b0;
      r_timer   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_valid  <= w_valid_nxt;
      r_prdata <= w_prdata_nxt;
      r_pready <= w_pready_nxt;
      r_perr   <= w_perr_nxt;
      r_timer  <= w_timer_nxt;
      if (w_accept) begin
        r_tidx    <= w_acc_tidx;
        r_rnw     <= ~apb_request__pwrite;
        r_select  <= apb_request__paddr[31:16];
        r_address <= {2'b00, apb_request__paddr[15:2]};
        r_data    <= apb_request__pwdata;
      end
    end
  end

  assign apb_response__prdata        = r_prdata;
  assign apb_response__pready        = r_pready;
  assign apb_response__perr          = r_perr;
  assign csr_request__valid          = r_valid;
  assign csr_request__read_not_write = r_rnw;
  assign csr_request__select         = r_select;
  assign csr_request__address        = r_address;
  assign csr_request__data           = r_data;

endmodule

// File: tb/tb_csr_master_apb_mt.sv
// Directed bench for csr_master_apb_mt: 4 targets, 8-cycle timeout.
module tb_csr_master_apb_mt;

  logic         clk;
  logic         reset;
  logic [31:0]  paddr, pwdata;
  logic         psel, penable, pwrite;
  logic [31:0]  prdata;
  logic         pready, perr;
  logic [3:0]   valid;
  logic         rnw;
  logic [15:0]  select, address;
  logic [31:0]  data;
  logic [3:0]   ack, rdv, rderr;
  logic [127:0] rdata;

  int total = 0;
  int bad = 0;
  int multi_hot = 0;

  csr_master_apb_mt #(
    .N_TARGETS      (4),
    .TIMEOUT_CYCLES (8),
    .ERR_DATA       (32'hDEADDEAD)
  ) dut (
    .clk                           (clk),
    .reset                         (reset),
    .apb_request__paddr            (paddr),
    .apb_request__psel             (psel),
    .apb_request__penable          (penable),
    .apb_request__pwrite           (pwrite),
    .apb_request__pwdata           (pwdata),
    .apb_response__prdata          (prdata),
    .apb_response__pready          (pready),
    .apb_response__perr            (perr),
    .csr_request__valid            (valid),
    .csr_request__read_not_write   (rnw),
    .csr_request__select           (select),
    .csr_request__address          (address),
    .csr_request__data             (data),
    .csr_response__acknowledge     (ack),
    .csr_response__read_data_valid (rdv),
    .csr_response__read_data_error (rderr),
    .csr_response__read_data       (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if ($countones(valid) > 1) multi_hot++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in;
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    ack = '0; rdv = '0; rderr = '0; rdata = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    clear_in();
    tick(); tick();
    total++; if (valid !== 4'b0000) begin bad++; $display("FAIL rst_valid got=%b exp=0000", valid); end
    total++; if (rnw !== 1'b0) begin bad++; $display("FAIL rst_rnw got=%b exp=0", rnw); end
    total++; if (select !== 16'h0 || address !== 16'h0) begin bad++; $display("FAIL rst_sel_addr got=%h/%h exp=0000/0000", select, address); end
    total++; if (data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", data); end
    total++; if (prdata !== 32'h0 || pready !== 1'b0 || perr !== 1'b0) begin bad++; $display("FAIL rst_apb got=%h/%b/%b exp=0/0/0", prdata, pready, perr); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write;
    paddr = 32'h0002_0010; pwdata = 32'h1234_5678; pwrite = 1; psel = 1; penable = 0;
    tick();
    total++; if (valid !== 4'b0000) begin bad++; $display("FAIL wr_setup_ignored got=%b exp=0000", valid); end
    penable = 1;
    tick();
    total++; if (valid !== 4'b0100) begin bad++; $display("FAIL wr_valid got=%b exp=0100", valid); end
    total++; if (rnw !== 1'b0) begin bad++; $display("FAIL wr_rnw got=%b exp=0", rnw); end
    total++; if (select !== 16'h0002) begin bad++; $display("FAIL wr_select got=%h exp=0002", select); end
    total++; if (address !== 16'h0004) begin bad++; $display("FAIL wr_address got=%h exp=0004", address); end
    total++; if (data !== 32'h1234_5678) begin bad++; $display("FAIL wr_data got=%h exp=12345678", data); end
    total++; if (pready !== 1'b0) begin bad++; $display("FAIL wr_early_pready got=%b exp=0", pready); end
    ack = 4'b0100;
    tick();
    total++; if (pready !== 1'b1 || perr !== 1'b0) begin bad++; $display("FAIL wr_done got=%b/%b exp=1/0", pready, perr); end
    total++; if (prdata !== 32'h0 || valid !== 4'b0000) begin bad++; $display("FAIL wr_done_fields got=%h/%b exp=0/0000", prdata, valid); end
    clear_in();
    tick();
    total++; if (pready !== 1'b0) begin bad++; $display("FAIL wr_pulse_width got=%b exp=0", pready); end
  endtask

  task automatic test_read;
    paddr = 32'h0001_0000; pwrite = 0; psel = 1; penable = 1;
    tick();
    total++; if (valid !== 4'b0010 || rnw !== 1'b1) begin bad++; $display("FAIL rd_valid got=%b/%b exp=0010/1", valid, rnw); end
    total++; if (select !== 16'h0001 || address !== 16'h0000) begin bad++; $display("FAIL rd_sel_addr got=%h/%h exp=0001/0000", select, address); end
    // Ack with same-cycle data on the target, plus noise on channel 0.
    ack = 4'b0011; rdv = 4'b0011;
    rdata = {32'h0, 32'h0, 32'hBAD0_BAD0, 32'h1111_1111};
    tick();
    total++; if (pready !== 1'b0 || valid !== 4'b0000) begin bad++; $display("FAIL rd_wait got=%b/%b exp=0/0000", pready, valid); end
    ack = 4'b0000; rdv = 4'b0110; rderr = 4'b0101;
    rdata = {32'h0, 32'h2222_2222, 32'hCAFE_F00D, 32'h1111_1111};
    tick();
    total++; if (pready !== 1'b1) begin bad++; $display("FAIL rd_pready got=%b exp=1", pready); end
    total++; if (prdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL rd_prdata got=%h exp=cafef00d", prdata); end
    total++; if (perr !== 1'b0) begin bad++; $display("FAIL rd_perr got=%b exp=0", perr); end
    clear_in();
    tick();
    total++; if (prdata !== 32'h0 || pready !== 1'b0) begin bad++; $display("FAIL rd_after got=%h/%b exp=0/0", prdata, pready); end
  endtask

  task automatic test_read_err;
    paddr = 32'h0003_0040; pwrite = 0; psel = 1; penable = 1;
    tick();
    total++; if (valid !== 4'b1000 || address !== 16'h0010) begin bad++; $display("FAIL rderr_req got=%b/%h exp=1000/0010", valid, address); end
    ack = 4'b1000;
    tick();
    ack = 4'b0000; rdv = 4'b1000; rderr = 4'b1000;
    rdata = {32'h1212_1212, 96'h0};
    tick();
    total++; if (pready !== 1'b1 || perr !== 1'b1) begin bad++; $display("FAIL rderr_flags got=%b/%b exp=1/1", pready, perr); end
    total++; if (prdata !== 32'hDEAD_DEAD) begin bad++; $display("FAIL rderr_prdata got=%h exp=deaddead", prdata); end
    clear_in();
    tick();
    total++; if (perr !== 1'b0) begin bad++; $display("FAIL rderr_clear got=%b exp=0", perr); end
  endtask

  task automatic test_timeout;
    paddr = 32'h0000_0008; pwrite = 0; psel = 1; penable = 1;
    tick();
    total++; if (valid !== 4'b0001) begin bad++; $display("FAIL to_valid got=%b exp=0001", valid); end
    for (int c = 2; c <= 8; c++) begin
      tick();
      total++; if (pready !== 1'b0) begin bad++; $display("FAIL to_early cyc=%0d got=%b exp=0", c, pready); end
    end
    tick();
    total++; if (pready !== 1'b1 || perr !== 1'b1) begin bad++; $display("FAIL to_done got=%b/%b exp=1/1", pready, perr); end
    total++; if (prdata !== 32'hDEAD_DEAD || valid !== 4'b0000) begin bad++; $display("FAIL to_fields got=%h/%b exp=deaddead/0000", prdata, valid); end
    clear_in();
    tick(); tick(); tick();
    ack = 4'b0001; rdv = 4'b0001; rdata = {96'h0, 32'h3333_3333};
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (pready !== 1'b0 || valid !== 4'b0000) begin bad++; $display("FAIL to_late cyc=%0d got=%b/%b exp=0/0000", c, pready, valid); end
    end
    clear_in();
    paddr = 32'h0002_0000; pwdata = 32'h7777_7777; pwrite = 1; psel = 1; penable = 1;
    tick();
    for (int c = 2; c <= 8; c++) tick();
    tick();
    total++; if (pready !== 1'b1 || perr !== 1'b1 || prdata !== 32'h0) begin bad++; $display("FAIL to_write got=%b/%b/%h exp=1/1/0", pready, perr, prdata); end
    clear_in();
    tick();
  endtask

  task automatic test_reset_mid;
    paddr = 32'h0001_0020; pwrite = 0; psel = 1; penable = 1;
    tick();
    total++; if (rnw !== 1'b1 || valid !== 4'b0010) begin bad++; $display("FAIL rm_req got=%b/%b exp=1/0010", rnw, valid); end
    ack = 4'b0010;
    tick();
    total++; if (select !== 16'h0001 || address !== 16'h0008) begin bad++; $display("FAIL rm_fields got=%h/%h exp=0001/0008", select, address); end
    #2 reset = 1'b1;
    #1;
    total++; if (select !== 16'h0 || address !== 16'h0 || rnw !== 1'b0) begin bad++; $display("FAIL rm_async got=%h/%h/%b exp=0/0/0", select, address, rnw); end
    total++; if (pready !== 1'b0 || valid !== 4'b0000 || prdata !== 32'h0) begin bad++; $display("FAIL rm_async_apb got=%b/%b/%h exp=0/0000/0", pready, valid, prdata); end
    #2 reset = 1'b0;
    clear_in();
    rdv = 4'b0010; rdata = {64'h0, 32'h4444_4444, 32'h0};
    tick();
    total++; if (pready !== 1'b0) begin bad++; $display("FAIL rm_stale got=%b exp=0", pready); end
    clear_in();
    paddr = 32'h0000_0004; pwdata = 32'h5A5A_5A5A; pwrite = 1; psel = 1; penable = 1;
    tick();
    total++; if (valid !== 4'b0001 || address !== 16'h0001 || data !== 32'h5A5A_5A5A) begin bad++; $display("FAIL rm_new_req got=%b/%h/%h exp=0001/0001/5a5a5a5a", valid, address, data); end
    ack = 4'b0001;
    tick();
    total++; if (pready !== 1'b1 || perr !== 1'b0) begin bad++; $display("FAIL rm_new_done got=%b/%b exp=1/0", pready, perr); end
    clear_in();
    tick();
  endtask

  task automatic test_back_to_back;
    paddr = 32'h0000_0000; pwdata = 32'hAAAA_0000; pwrite = 1; psel = 1; penable = 1;
    tick();
    total++; if (valid !== 4'b0001) begin bad++; $display("FAIL b2b_v0 got=%b exp=0001", valid); end
    ack = 4'b0001;
    tick();
    total++; if (pready !== 1'b1) begin bad++; $display("FAIL b2b_p0 got=%b exp=1", pready); end
    paddr = 32'h0001_0000; pwdata = 32'hBBBB_1111; ack = 4'b0000;
    tick();
    total++; if (pready !== 1'b0 || valid !== 4'b0000) begin bad++; $display("FAIL b2b_gap got=%b/%b exp=0/0000", pready, valid); end
    tick();
    total++; if (valid !== 4'b0010 || data !== 32'hBBBB_1111) begin bad++; $display("FAIL b2b_v1 got=%b/%h exp=0010/bbbb1111", valid, data); end
    ack = 4'b0010;
    tick();
    total++; if (pready !== 1'b1 || perr !== 1'b0) begin bad++; $display("FAIL b2b_p1 got=%b/%b exp=1/0", pready, perr); end
    clear_in();
    tick();
    total++; if (multi_hot !== 0) begin bad++; $display("FAIL valid_onehot got=%0d exp=0", multi_hot); end
  endtask

  initial begin
    reset = 1'b1;
    clear_in();
    test_reset();
    test_write();
    test_read();
    test_read_err();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
